// File: rtl/ram_pkg.sv
// ram_pkg: shared defaults and read-path selection for the ram block.
//   RAM_AWIDTH_DEF / RAM_DWIDTH_DEF : default address / data widths
//   rd_src_e                        : where the next rdata value comes from
//   rd_src()                        : picks the rdata source for one edge
package ram_pkg;

   localparam int unsigned RAM_AWIDTH_DEF = 4;
   localparam int unsigned RAM_DWIDTH_DEF = 8;

   typedef enum logic [1:0] {
      RD_HOLD  = 2'd0,   // re low: keep the previous read result
      RD_MEM   = 2'd1,   // normal array read
      RD_FWD   = 2'd2,   // same-edge write to the read address: return wdata
      RD_CLEAR = 2'd3    // reset: force rdata to zero
   } rd_src_e;

   // Reset dominates everything; a same-address write wins over the stale
   // array contents so the read sees the word being written this edge.
   function automatic rd_src_e rd_src(input logic rst, input logic re, input logic hit);
      rd_src_e src;
      if (rst)
         src = RD_CLEAR;
      else if (!re)
         src = RD_HOLD;
      else if (hit)
         src = RD_FWD;
      else
         src = RD_MEM;
      return src;
   endfunction

endpackage

// File: rtl/ram.sv
// ram: simple dual-port RAM, one write port and one registered read port.
//   clk   : single clock, all state updates on the rising edge
//   rst   : synchronous active-high reset; clears rdata only, not the array
//   re    : read enable;  raddr selects the word, result on rdata next clock
//   rdata : registered read data, holds its value while re is low
//   we    : write enable; mem[waddr] <= wdata
// A read and a write to the same address on one edge return the new wdata.
module ram
   import ram_pkg::*;
#(
   parameter int unsigned AWIDTH = RAM_AWIDTH_DEF,
   parameter int unsigned DWIDTH = RAM_DWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              re,
   input  logic [AWIDTH-1:0] raddr,
   output logic [DWIDTH-1:0] rdata,
   input  logic              we,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [DWIDTH-1:0] wdata
);

   localparam int unsigned DEPTH = 2 ** AWIDTH;

   // Plain register array so synthesis can map it to block or distributed RAM.
   // It has no reset: contents written before a reset stay readable afterwards.
   logic [DWIDTH-1:0] mem_q [DEPTH];

   logic [DWIDTH-1:0] rdata_d;
   logic [DWIDTH-1:0] rdata_q;
   logic              hit;
   rd_src_e           src;

   always_ff @(posedge clk) begin
      if (!rst && we)
         mem_q[waddr] <= wdata;
   end

   always_comb begin
      hit     = we && (waddr == raddr);
      src     = rd_src(rst, re, hit);
      rdata_d = rdata_q;
      unique case (src)
         RD_CLEAR: rdata_d = '0;
         RD_FWD:   rdata_d = wdata;
         RD_MEM:   rdata_d = mem_q[raddr];
         default:  rdata_d = rdata_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         rdata_q <= '0;
      else
         rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: tb/tb_ram.sv
module tb_ram;

   logic       clk;
   logic       rst;
   logic       re;
   logic [3:0] raddr;
   logic [7:0] rdata;
   logic       we;
   logic [3:0] waddr;
   logic [7:0] wdata;

   ram #(.AWIDTH(4), .DWIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .re    (re),
      .raddr (raddr),
      .rdata (rdata),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst;
      logic       we;
      logic [3:0] waddr;
      logic [7:0] wdata;
      logic       re;
      logic [3:0] raddr;
      logic       chk;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb_q[$];
   string      sb_name[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_mem [16];
   logic [7:0] model_rd;

   function automatic void add(input string n, input logic r, input logic w,
                               input logic [3:0] wa, input logic [7:0] wd,
                               input logic rr, input logic [3:0] ra,
                               input logic c, input logic [7:0] e);
      vec_t v;
      v.name = n; v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd;
      v.re = rr; v.raddr = ra; v.chk = c; v.exp = e;
      vecs.push_back(v);
   endfunction

   // Drive one cycle at the falling edge, push the expectation, then compare
   // rdata 1 ns after the rising edge that consumed the stimulus.
   task automatic step(input vec_t v);
      logic [7:0] e;
      string      n;
      @(negedge clk);
      rst = v.rst; we = v.we; waddr = v.waddr; wdata = v.wdata;
      re = v.re; raddr = v.raddr;
      if (v.chk) begin
         sb_q.push_back(v.exp);
         sb_name.push_back(v.name);
      end
      @(posedge clk);
      #1;
      if (v.chk) begin
         e = sb_q.pop_front();
         n = sb_name.pop_front();
         checks++;
         if (rdata !== e) begin
            errors++;
            $display("FAIL %s: rdata=0x%02h expected 0x%02h", n, rdata, e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      vec_t v;
      rst = 1'b1; re = 1'b0; we = 1'b0; raddr = '0; waddr = '0; wdata = '0;

      // reset held two cycles with re=1
      add("reset0", 1, 0, 0, 8'h00, 1, 4'd9, 1, 8'h00);
      add("reset1", 1, 0, 0, 8'h00, 1, 4'd9, 1, 8'h00);
      // fill mem[i]=i, rdata must hold 0 since re is low
      for (int unsigned i = 0; i < 16; i++)
         add("fill_hold", 0, 1, 4'(i), 8'(i), 0, 4'(15 - i), (i == 15), 8'h00);
      for (int unsigned i = 0; i < 16; i++)
         add($sformatf("read%0d", i), 0, 0, 0, 8'h00, 1, 4'(i), 1, 8'(i));
      // hold
      add("hold_rd5", 0, 0, 0, 8'h00, 1, 4'd5, 1, 8'h05);
      add("hold1",    0, 0, 0, 8'h00, 0, 4'd1, 1, 8'h05);
      add("hold2",    0, 0, 0, 8'h00, 0, 4'd9, 1, 8'h05);
      add("hold3",    0, 0, 0, 8'h00, 0, 4'd14, 1, 8'h05);
      // collision, then confirm the array took the write too
      add("collide",    0, 1, 4'd3, 8'hA5, 1, 4'd3, 1, 8'hA5);
      add("collide_rb", 0, 0, 0,    8'h00, 1, 4'd3, 1, 8'hA5);
      // concurrent different addresses
      add("concur_rd2", 0, 1, 4'd7, 8'h3C, 1, 4'd2, 1, 8'h02);
      add("concur_rd7", 0, 0, 0,    8'h00, 1, 4'd7, 1, 8'h3C);
      // reset persistence; write attempted during reset must be dropped
      add("pers_wr",    0, 1, 4'd15, 8'h5A, 0, 4'd0, 1, 8'h3C);
      add("pers_rst",   1, 1, 4'd15, 8'hFF, 1, 4'd15, 1, 8'h00);
      add("pers_rd15",  0, 0, 0,     8'h00, 1, 4'd15, 1, 8'h5A);
      add("pers_rd0",   0, 0, 0,     8'h00, 1, 4'd0, 1, 8'h00);

      for (int unsigned k = 0; k < vecs.size(); k++)
         step(vecs[k]);

      // Random mix against a behavioural model; all locations are defined now.
      for (int unsigned i = 0; i < 16; i++) model_mem[i] = 8'(i);
      model_mem[3] = 8'hA5; model_mem[7] = 8'h3C; model_mem[15] = 8'h5A;
      model_rd = 8'h00;
      for (int unsigned k = 0; k < 200; k++) begin
         v.name  = "random";
         v.rst   = ($urandom_range(0, 19) == 0);
         v.we    = 1'($urandom);
         v.waddr = 4'($urandom);
         v.wdata = 8'($urandom);
         v.re    = 1'($urandom);
         v.raddr = ($urandom_range(0, 3) == 0) ? v.waddr : 4'($urandom);
         if (v.rst)
            model_rd = 8'h00;
         else if (v.re)
            model_rd = (v.we && v.waddr == v.raddr) ? v.wdata : model_mem[v.raddr];
         if (!v.rst && v.we)
            model_mem[v.waddr] = v.wdata;
         v.chk = 1'b1;
         v.exp = model_rd;
         step(v);
      end

      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 AWIDTH, default 4, address width in bits; depth is 2**AWIDTH words.
REQ-002 DWIDTH, default 8, data width in bits per word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 re  input  1  read enable, sampled at rising edge of clk.
REQ-006 raddr  input  AWIDTH  read address.
REQ-007 rdata  output  DWIDTH  registered read data.
REQ-008 we  input  1  write enable, sampled at rising edge of clk.
REQ-009 waddr  input  AWIDTH  write address.
REQ-010 wdata  input  DWIDTH  write data.

Function
REQ-011 Storage SHALL be a simple dual-port array of 2**AWIDTH words of DWIDTH bits, with one write port and one read port usable in the same cycle.
REQ-012 On a rising edge with we=1 and rst=0, mem[waddr] SHALL take wdata; with we=0, no location SHALL change.
REQ-013 On a rising edge with re=1 and rst=0, rdata SHALL take mem[raddr]; the read latency is exactly one clock.
REQ-014 With re=0, rdata SHALL hold its previous value.
REQ-015 Read and write to the same address in the same edge (re=1, we=1, raddr==waddr) SHALL return the new wdata on rdata (write-first forwarding).
REQ-016 Read and write to different addresses in the same edge SHALL be independent; the write SHALL not disturb the read result.
REQ-017 Addresses SHALL cover the full range 0..2**AWIDTH-1 with no aliasing; no out-of-range case exists.
REQ-018 A location never written since power-up SHALL read as an unspecified value; benches SHALL NOT check it.
REQ-019 No handshake or back-pressure exists; every enabled access completes in the cycle it is presented.

Reset
REQ-020 While rst=1 at a rising edge, rdata SHALL be cleared to all zeros.
REQ-021 While rst=1, writes and reads SHALL be suppressed regardless of we and re.
REQ-022 Reset SHALL NOT clear the memory array; contents written before reset SHALL be readable after reset deasserts.
REQ-023 The first access after rst falls SHALL be accepted on the first rising edge with rst=0.

Structure
REQ-024 No shared package is required; AWIDTH and DWIDTH are module parameters only.
REQ-025 The block SHALL be a single module with no sub-modules.
REQ-026 The storage SHALL be written as a plain register array so synthesis can infer block or distributed RAM; rdata SHALL be the only register outside the array.

Verification
REQ-027 Reset: hold rst=1 for 2 cycles with re=1 -> rdata=0x00 throughout reset.
REQ-028 Fill-then-read: write mem[i]=i for i=0..15, then read i=0..15 one at a time -> rdata=i one clock after each read strobe, 16/16 matches.
REQ-029 Hold: read address 5 (value 0x05), then drop re for 3 cycles while changing raddr -> rdata stays 0x05.
REQ-030 Collision: write 0xA5 to address 3 while re=1, raddr=3 in the same edge -> rdata=0xA5 one clock later.
REQ-031 Concurrent: write 0x3C to address 7 while reading address 2 (holding 0x02) -> rdata=0x02; a subsequent read of address 7 -> 0x3C.
REQ-032 Reset persistence: write 0x5A to address 15, pulse rst for 1 cycle, read address 15 -> rdata=0x00 during reset, then 0x5A after the read.
